// File: rtl/triple_out_arbiter.sv
// Round-robin arbiter that lends one bank of three output words to one of NUM_REQ
// requesters at a time. Each grant is one LOAD cycle followed by HOLD_CYCLES valid cycles.
module triple_out_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 32,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*3*WIDTH-1:0] payload,
  output logic [NUM_REQ-1:0]         grant,
  output logic [WIDTH-1:0]           out1,
  output logic [WIDTH-1:0]           out2,
  output logic [WIDTH-1:0]           out3,
  output logic                       out_valid,
  output logic                       busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   sel_q, sel_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [WIDTH-1:0]   out1_q, out1_d;
  logic [WIDTH-1:0]   out2_q, out2_d;
  logic [WIDTH-1:0]   out3_q, out3_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH-1:0]   words [NUM_REQ][3];
  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   cand_idx;
  int                 cand;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < 3; k++) begin
        words[i][k] = payload[(3*i+k)*WIDTH +: WIDTH];
      end
    end
  end

  // Scan from ptr upward with an explicit wrap so non-power-of-2 counts need no modulo.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!pick_found && req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    grant_d     = '0;
    out1_d      = out1_q;
    out2_d      = out2_q;
    out3_d      = out3_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (pick_found) begin
          sel_d   = pick_idx;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        out1_d      = words[sel_q][0];
        out2_d      = words[sel_q][1];
        out3_d      = words[sel_q][2];
        out_valid_d = 1'b1;
        cnt_d       = CNT_W'(HOLD_CYCLES - 1);
        ptr_d       = (sel_q == PTR_W'(NUM_REQ - 1)) ? '0 : sel_q + PTR_W'(1);
        state_d     = HOLD;
      end
      HOLD: begin
        if (cnt_q == '0) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      out1_q      <= '0;
      out2_q      <= '0;
      out3_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
      out3_q      <= out3_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign grant     = grant_q;
  assign out1      = out1_q;
  assign out2      = out2_q;
  assign out3      = out3_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_triple_out_arbiter.sv
// Directed bench for triple_out_arbiter: a transaction-timeline model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_triple_out_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int HOLD    = 2;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*3*WIDTH-1:0] payload;
  logic [NUM_REQ-1:0]         grant;
  logic [WIDTH-1:0]           out1, out2, out3;
  logic                       out_valid, busy;

  int checks   = 0;
  int failures = 0;

  triple_out_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .req(req), .payload(payload), .grant(grant),
    .out1(out1), .out2(out2), .out3(out3), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [WIDTH-1:0] pay_word(input int i, input int k);
    if (i == 0) return WIDTH'(10 * (k + 1));
    return WIDTH'(32'h1000_0000 + i * 16 + k);
  endfunction

  // Model: phase 0 idle, 1 grant cycle, 2..1+HOLD valid cycles.
  logic               model_valid = 1'b0;
  int                 m_phase, m_ptr, m_sel, m_idx;
  logic [NUM_REQ-1:0] e_grant;
  logic [WIDTH-1:0]   e_out [3];
  logic               e_valid;

  always @(posedge clk) begin
    if (reset) begin
      model_valid = 1'b1;
      m_phase = 0;
      m_ptr   = 0;
      m_sel   = 0;
      e_grant = '0;
      e_valid = 1'b0;
      for (int k = 0; k < 3; k++) e_out[k] = '0;
    end else if (model_valid) begin
      e_grant = '0;
      if (m_phase == 0) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          m_idx = (m_ptr + i) % NUM_REQ;
          if (m_phase == 0 && req[m_idx]) begin
            m_sel = m_idx;
            m_phase = 1;
            e_grant[m_idx] = 1'b1;
          end
        end
      end else if (m_phase == 1) begin
        for (int k = 0; k < 3; k++) e_out[k] = payload[(3*m_sel+k)*WIDTH +: WIDTH];
        e_valid = 1'b1;
        m_ptr   = (m_sel + 1) % NUM_REQ;
        m_phase = 2;
      end else if (m_phase == 1 + HOLD) begin
        m_phase = 0;
        e_valid = 1'b0;
      end else begin
        m_phase++;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (model_valid) begin
      check("model grant", grant, e_grant);
      check("model out1", out1, e_out[0]);
      check("model out2", out2, e_out[1]);
      check("model out3", out3, e_out[2]);
      check("model out_valid", out_valid, e_valid);
      check("model busy", busy, m_phase != 0);
    end
  end

  initial begin
    logic [NUM_REQ-1:0] exp_g [5];
    int                 exp_i [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_i = '{0, 1, 2, 3, 0};

    // 1: random activity, then reset held two cycles
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req = NUM_REQ'($urandom);
      for (int w = 0; w < NUM_REQ * 3; w++) payload[w*WIDTH +: WIDTH] = $urandom;
      tick(1);
    end
    reset = 1'b1;
    req   = '0;
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < 3; k++) payload[(3*i+k)*WIDTH +: WIDTH] = pay_word(i, k);
    tick(2);
    check("reset grant", grant, 4'b0000);
    check("reset out1", out1, 32'h0);
    check("reset out2", out2, 32'h0);
    check("reset out3", out3, 32'h0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    reset = 1'b0;

    // 2: single request from requester 0
    req = 4'b0001;
    tick(1);
    check("single grant", grant, 4'b0001);
    req = '0;
    for (int c = 0; c < 2; c++) begin
      tick(1);
      check("single out1", out1, 32'h0000000A);
      check("single out2", out2, 32'h00000014);
      check("single out3", out3, 32'h0000001E);
      check("single out_valid", out_valid, 1'b1);
    end
    tick(1);
    check("single end out_valid", out_valid, 1'b0);
    check("single end busy", busy, 1'b0);
    check("single retained out1", out1, 32'h0000000A);

    // 3: round robin with all requesting, starting from ptr 0
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick(1);
      check("rr grant", grant, exp_g[g]);
      tick(1);
      check("rr out1", out1, pay_word(exp_i[g], 0));
      check("rr out2", out2, pay_word(exp_i[g], 1));
      check("rr out3", out3, pay_word(exp_i[g], 2));
      if (g == 1) check("rr literal req1 out1", out1, 32'h10000010);
      tick(2);
    end

    // 4: serve requester 2 (ptr -> 3), then 1001 picks 3 and wraps to 0
    req = 4'b0100;
    tick(1);
    check("wrap grant2", grant, 4'b0100);
    req = '0;
    tick(3);
    req = 4'b1001;
    tick(1);
    check("wrap grant3", grant, 4'b1000);
    req = 4'b0001;
    tick(1);
    check("wrap out1 req3", out1, 32'h10000030);
    tick(2);
    tick(1);
    check("wrap grant0", grant, 4'b0001);
    req = '0;

    // 5: reset in the first HOLD cycle aborts the transfer
    tick(1);
    check("abort pre out_valid", out_valid, 1'b1);
    reset = 1'b1;
    tick(1);
    check("abort grant", grant, 4'b0000);
    check("abort out_valid", out_valid, 1'b0);
    check("abort out1", out1, 32'h0);
    check("abort out3", out3, 32'h0);
    check("abort busy", busy, 1'b0);
    reset = 1'b0;
    req = 4'b1111;
    tick(1);
    check("post abort grant", grant, 4'b0001);
    req = '0;

    // 6: a req pulse during HOLD is ignored
    tick(1);
    req = 4'b0010;
    tick(1);
    req = '0;
    tick(1);
    for (int c = 0; c < 6; c++) begin
      tick(1);
      check("ignored grant", grant, 4'b0000);
      check("ignored busy", busy, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
